// File: rtl/fetch_redirect_pkg.sv
// Shared types for the fetch stage: basic widths, the fetch FSM state encoding,
// and the bundle handed to decode.
package fetch_redirect_pkg;

  typedef logic        u1;
  typedef logic [31:0] u32;
  typedef logic [63:0] u64;

  typedef enum logic [1:0] {
    S_BOOT,
    S_REQ,
    S_WAIT,
    S_HOLD
  } fetch_state_t;

  typedef struct packed {
    u64 pc;
    u32 instr;
    u1  misalign;
  } fetch_out_t;

  localparam u64 PC_RESET = 64'h8000_0000;

endpackage

// File: rtl/fetch_redirect.sv
// Fetch-stage PC owner: issues instruction-bus requests, buffers one instruction
// for decode, and applies execute-stage redirects while respecting bus stability.
module fetch_redirect
  import fetch_redirect_pkg::*;
#(
  parameter u64 RESET_PC = PC_RESET
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        flush,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_addr_ok,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [63:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_misalign
);

  fetch_state_t state_q, state_d;
  u64           pc_q, pc_d;
  u64           pend_pc_q, pend_pc_d;
  logic         drop_q, drop_d;
  u32           instr_q, instr_d;
  logic         misalign_q, misalign_d;
  logic         aligned;
  logic         hold;
  fetch_out_t   if_out;

  assign aligned = (pc_q[1:0] == 2'b00);
  assign hold    = (state_q == S_HOLD);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      pend_pc_q  <= '0;
      drop_q     <= 1'b0;
      instr_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_pc_q  <= pend_pc_d;
      drop_q     <= drop_d;
      instr_q    <= instr_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_pc_d  = pend_pc_q;
    drop_d     = drop_q;
    instr_d    = instr_q;
    misalign_d = misalign_q;
    unique case (state_q)
      S_BOOT: begin
        if (redirect_valid) pc_d = redirect_pc;
        state_d = S_REQ;
      end
      S_REQ: begin
        if (!aligned) begin
          // Nothing was put on the bus, so a redirect can replace pc outright.
          if (redirect_valid) begin
            pc_d = redirect_pc;
          end else begin
            misalign_d = 1'b1;
            instr_d    = '0;
            state_d    = S_HOLD;
          end
        end else begin
          if (redirect_valid) begin
            pend_pc_d = redirect_pc;
            drop_d    = 1'b1;
          end
          if (iresp_addr_ok) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (iresp_data_ok) begin
          if (redirect_valid) begin
            pc_d    = redirect_pc;
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else if (drop_q) begin
            pc_d    = pend_pc_q;
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            instr_d    = iresp_data;
            misalign_d = 1'b0;
            state_d    = S_HOLD;
          end
        end else if (redirect_valid) begin
          pend_pc_d = redirect_pc;
          drop_d    = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = S_REQ;
        end else if (if_ready) begin
          pc_d    = pc_q + 64'd4;
          state_d = S_REQ;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  always_comb begin
    if_out = '0;
    if (hold) begin
      if_out.pc       = pc_q;
      if_out.instr    = instr_q;
      if_out.misalign = misalign_q;
    end
  end

  assign flush       = redirect_valid;
  assign ireq_valid  = (state_q == S_REQ) && aligned;
  assign ireq_addr   = ireq_valid ? pc_q : '0;
  assign if_valid    = hold && !redirect_valid;
  assign if_pc       = if_out.pc;
  assign if_instr    = if_out.instr;
  assign if_misalign = if_out.misalign;

endmodule
